// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths, ALU function encodings and the forwarding bus payload.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned FSEL_W = 3;

    localparam logic [FSEL_W-1:0] FSEL_ZERO = 3'b000;
    localparam logic [FSEL_W-1:0] FSEL_ADD  = 3'b001;
    localparam logic [FSEL_W-1:0] FSEL_SUB  = 3'b010;
    localparam logic [FSEL_W-1:0] FSEL_NEG  = 3'b011;
    localparam logic [FSEL_W-1:0] FSEL_XOR  = 3'b100;
    localparam logic [FSEL_W-1:0] FSEL_NOT  = 3'b101;
    localparam logic [FSEL_W-1:0] FSEL_PASS = 3'b110;

    localparam logic [REG_AW-1:0] R0 = 3'd0;

    // One writeback bus as seen by the operand stage
    typedef struct packed {
        logic              wb_en;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] result;
    } fwd_bus_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Three-way operand select: R0 forces zero, then EX/MEM, then MEM/WB, then default data.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] tag,
    input  logic [DATA_W-1:0] dflt,
    input  fwd_bus_t          exm,
    input  fwd_bus_t          mwb,
    output logic [DATA_W-1:0] sel_c
);

    always_comb begin
        sel_c = dflt;
        if (tag == R0) begin
            sel_c = '0;
        end else if (exm.wb_en && (exm.rd == tag)) begin
            sel_c = exm.result;
        end else if (mwb.wb_en && (mwb.rd == tag)) begin
            sel_c = mwb.result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW forwarding at capture and snooping while stalled.
module id_ex_operand_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [FSEL_W-1:0] id_fsel,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic [DATA_W-1:0] id_data_a,
    input  logic [DATA_W-1:0] id_data_b,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wb_en,
    input  logic              stall,
    input  logic              flush,
    input  logic              exm_wb_en,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_wb_en,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [FSEL_W-1:0] alu_fsel,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wb_en
);

    fwd_bus_t          exm_bus;
    fwd_bus_t          mwb_bus;
    logic [REG_AW-1:0] ex_rs_a;
    logic [REG_AW-1:0] ex_rs_b;
    logic [DATA_W-1:0] cap_a_c;
    logic [DATA_W-1:0] cap_b_c;
    logic [DATA_W-1:0] snoop_a_c;
    logic [DATA_W-1:0] snoop_b_c;

    assign exm_bus = '{wb_en: exm_wb_en, rd: exm_rd, result: exm_result};
    assign mwb_bus = '{wb_en: mwb_wb_en, rd: mwb_rd, result: mwb_result};

    fwd_mux u_cap_a   (.tag(id_rs_a), .dflt(id_data_a), .exm(exm_bus), .mwb(mwb_bus), .sel_c(cap_a_c));
    fwd_mux u_cap_b   (.tag(id_rs_b), .dflt(id_data_b), .exm(exm_bus), .mwb(mwb_bus), .sel_c(cap_b_c));
    fwd_mux u_snoop_a (.tag(ex_rs_a), .dflt(alu_x),     .exm(exm_bus), .mwb(mwb_bus), .sel_c(snoop_a_c));
    fwd_mux u_snoop_b (.tag(ex_rs_b), .dflt(alu_y),     .exm(exm_bus), .mwb(mwb_bus), .sel_c(snoop_b_c));

    // Priority per edge: flush, then stall (hold + snoop), then load or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_wb_en <= 1'b0;
            ex_rd    <= '0;
            alu_fsel <= FSEL_ZERO;
            alu_x    <= '0;
            alu_y    <= '0;
            ex_rs_a  <= '0;
            ex_rs_b  <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_valid <= 1'b0;
            ex_wb_en <= 1'b0;
            ex_rd    <= '0;
            alu_fsel <= FSEL_ZERO;
            alu_x    <= '0;
            alu_y    <= '0;
            ex_rs_a  <= '0;
            ex_rs_b  <= '0;
        end else if (stall) begin
            if (ex_valid) begin
                alu_x <= snoop_a_c;
                alu_y <= snoop_b_c;
            end
        end else begin
            ex_valid <= 1'b1;
            ex_wb_en <= id_wb_en;
            ex_rd    <= id_rd;
            alu_fsel <= id_fsel;
            alu_x    <= cap_a_c;
            alu_y    <= cap_b_c;
            ex_rs_a  <= id_rs_a;
            ex_rs_b  <= id_rs_b;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a behavioural model predicts each cycle's outputs.
module tb_id_ex_operand_stage;
    import cpu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [2:0]        id_fsel;
    logic [2:0]        id_rs_a, id_rs_b, id_rd;
    logic [15:0]       id_data_a, id_data_b;
    logic              id_wb_en, stall, flush;
    logic              exm_wb_en, mwb_wb_en;
    logic [2:0]        exm_rd, mwb_rd;
    logic [15:0]       exm_result, mwb_result;
    logic [15:0]       alu_x, alu_y;
    logic [2:0]        alu_fsel, ex_rd;
    logic              ex_valid, ex_wb_en;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_fsel(id_fsel),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
        .id_data_a(id_data_a), .id_data_b(id_data_b),
        .id_rd(id_rd), .id_wb_en(id_wb_en),
        .stall(stall), .flush(flush),
        .exm_wb_en(exm_wb_en), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_wb_en(mwb_wb_en), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_x(alu_x), .alu_y(alu_y), .alu_fsel(alu_fsel),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en)
    );

    typedef struct {
        logic        v;
        logic        wb;
        logic [2:0]  rd;
        logic [2:0]  f;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    exp_t        expq[$];
    exp_t        m;
    logic [2:0]  m_rsa, m_rsb;
    int          n_vec = 0;
    int          n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value a source register resolves to given the buses currently on the wires
    function automatic logic [15:0] resolve(input logic [2:0] r, input logic [15:0] rf);
        if (r == 3'd0) return 16'h0000;
        if (exm_wb_en && exm_rd == r) return exm_result;
        if (mwb_wb_en && mwb_rd == r) return mwb_result;
        return rf;
    endfunction

    function automatic exp_t empty_stage();
        exp_t e;
        e.v = 1'b0; e.wb = 1'b0; e.rd = 3'd0; e.f = 3'd0; e.x = 16'h0; e.y = 16'h0;
        return e;
    endfunction

    // Reference model: advances one instruction slot per edge and queues the outputs it expects
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expq.delete();
            m = empty_stage();
            m_rsa = 3'd0; m_rsb = 3'd0;
        end else if (flush || (!stall && !id_valid)) begin
            m = empty_stage();
            m_rsa = 3'd0; m_rsb = 3'd0;
        end else if (stall) begin
            if (m.v) begin
                m.x = resolve(m_rsa, m.x);
                m.y = resolve(m_rsb, m.y);
            end
        end else begin
            m.v = 1'b1; m.wb = id_wb_en; m.rd = id_rd; m.f = id_fsel;
            m.x = resolve(id_rs_a, id_data_a);
            m.y = resolve(id_rs_b, id_data_b);
            m_rsa = id_rs_a; m_rsb = id_rs_b;
        end
        expq.push_back(m);
    end

    // Monitor: every cycle the stage presents a result, check it against the oldest prediction
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_vec++;
            if (ex_valid !== e.v || ex_wb_en !== e.wb || ex_rd !== e.rd ||
                alu_fsel !== e.f || alu_x !== e.x || alu_y !== e.y) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got v=%b wb=%b rd=%0d f=%0d x=%h y=%h exp v=%b wb=%b rd=%0d f=%0d x=%h y=%h",
                         $time, ex_valid, ex_wb_en, ex_rd, alu_fsel, alu_x, alu_y,
                         e.v, e.wb, e.rd, e.f, e.x, e.y);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic ew, input logic [2:0] er, input logic [15:0] ed,
                       input logic mw, input logic [2:0] mr, input logic [15:0] md);
        exm_wb_en = ew; exm_rd = er; exm_result = ed;
        mwb_wb_en = mw; mwb_rd = mr; mwb_result = md;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [15:0] da, input logic [15:0] db, input logic [2:0] rd,
                         input logic wb, input logic st, input logic fl);
        id_valid = v; id_fsel = f; id_rs_a = ra; id_rs_b = rb;
        id_data_a = da; id_data_b = db; id_rd = rd; id_wb_en = wb;
        stall = st; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 16'(ex_valid), 16'h0);
        check("rst_fsel", 16'(alu_fsel), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        drive(1, FSEL_ADD, 1, 2, 16'h0005, 16'h0003, 3'd5, 1, 0, 0);
        step();
        check("load_x", alu_x, 16'h0005);
        check("load_y", alu_y, 16'h0003);
        check("load_fsel", 16'(alu_fsel), 16'(FSEL_ADD));
        check("load_valid", 16'(ex_valid), 16'h1);

        bus(1, 3, 16'h1111, 1, 3, 16'h2222);
        drive(1, FSEL_SUB, 3, 1, 16'h0000, 16'h0007, 3'd2, 1, 0, 0);
        step();
        check("fwd_exm", alu_x, 16'h1111);
        bus(0, 3, 16'h1111, 1, 3, 16'h2222);
        step();
        check("fwd_mwb", alu_x, 16'h2222);

        bus(1, 0, 16'hFFFF, 0, 0, 0);
        drive(1, FSEL_XOR, 1, 0, 16'h0042, 16'h1234, 3'd0, 1, 0, 0);
        step();
        check("r0_y", alu_y, 16'h0000);
        check("r0_wb_passthru", 16'(ex_wb_en), 16'h1);

        bus(0, 0, 0, 0, 0, 0);
        drive(1, FSEL_PASS, 4, 5, 16'h0001, 16'h0009, 3'd6, 1, 0, 0);
        step();
        drive(1, FSEL_NOT, 1, 1, 16'h7777, 16'h7777, 3'd1, 0, 1, 0);
        step();
        check("stall_hold_x", alu_x, 16'h0001);
        bus(0, 0, 0, 1, 4, 16'hABCD);
        step();
        check("snoop_x", alu_x, 16'hABCD);
        check("snoop_y", alu_y, 16'h0009);
        check("snoop_fsel", 16'(alu_fsel), 16'(FSEL_PASS));
        check("snoop_rd", 16'(ex_rd), 16'h6);

        bus(0, 0, 0, 0, 0, 0);
        drive(1, FSEL_ADD, 1, 2, 16'h1, 16'h2, 3'd3, 1, 1, 1);
        step();
        check("flush_valid", 16'(ex_valid), 16'h0);
        check("flush_wb", 16'(ex_wb_en), 16'h0);
        check("flush_fsel", 16'(alu_fsel), 16'h0);
        check("flush_xy", alu_x | alu_y, 16'h0);

        bus(1, 1, 16'h5555, 1, 2, 16'h6666);
        drive(1, FSEL_ADD, 1, 2, 16'h1, 16'h2, 3'd3, 1, 1, 0);
        step();
        check("stall_bubble_valid", 16'(ex_valid), 16'h0);
        check("stall_bubble_x", alu_x, 16'h0);

        bus(1, 6, 16'hBEEF, 0, 0, 0);
        drive(1, FSEL_XOR, 6, 6, 16'h0101, 16'h0202, 3'd7, 1, 0, 0);
        step();
        check("same_src_x", alu_x, 16'hBEEF);
        check("same_src_y", alu_y, 16'hBEEF);

        bus(0, 0, 0, 0, 0, 0);
        drive(1, FSEL_NEG, 2, 3, 16'h0A0A, 16'h0B0B, 3'd4, 1, 1, 0);
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 16'(ex_valid), 16'h0);
        check("async_rst_fsel", 16'(alu_fsel), 16'h0);
        check("async_rst_x", alu_x, 16'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        check("rst_mid_stall", 16'(ex_valid), 16'h0);

        for (int i = 0; i < 400; i++) begin
            bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 3'($urandom),
                  16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
            step();
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
